// File: rtl/product_display_driver.sv
// Sequential double-dabble converter for a 9-bit product feeding a 3-digit multiplexed 7-segment display.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros on the tens and hundreds digits.
module product_display_driver #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] m,
    input  logic       load,
    output logic       busy,
    output logic       done,
    output logic [2:0] an,
    output logic [6:0] seg
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] RCNT_LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [11:0]   bcd;
    logic [8:0]    sh;
    logic [3:0]    iter;
    logic [3:0]    d0, d1, d2;
    logic [CW-1:0] rcnt;
    logic [1:0]    idx;

    logic [11:0]   adj;
    logic [20:0]   sr_next;
    logic [2:0]    an_sel;
    logic [3:0]    dig_sel;
    logic          blank_sel;
    logic          blank_tens, blank_hund;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // One double-dabble iteration: correct nibbles >= 5, then shift {bcd,sh} left.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        sr_next = {adj, sh} << 1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            sh    <= '0;
            iter  <= '0;
            d0    <= '0;
            d1    <= '0;
            d2    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        sh    <= m;
                        bcd   <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd  <= sr_next[20:9];
                    sh   <= sr_next[8:0];
                    iter <= iter + 4'd1;
                    if (iter == 4'd8) begin
                        d0    <= sr_next[12:9];
                        d1    <= sr_next[16:13];
                        d2    <= sr_next[20:17];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign blank_hund = (d2 == 4'd0);
    assign blank_tens = (d2 == 4'd0) && (d1 == 4'd0);
`else
    assign blank_hund = 1'b0;
    assign blank_tens = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        an_sel    = 3'b111;
        dig_sel   = 4'd0;
        blank_sel = 1'b0;
        case (idx)
            2'd0: begin an_sel = 3'b110; dig_sel = d0; end
            2'd1: begin an_sel = 3'b101; dig_sel = d1; blank_sel = blank_tens; end
            2'd2: begin an_sel = 3'b011; dig_sel = d2; blank_sel = blank_hund; end
            default: ;
        endcase
    end

    // Free-running refresh scan; the digit index steps once per counter wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= 2'd0;
            an   <= 3'b111;
            seg  <= 7'h7F;
        end else begin
            if (rcnt == RCNT_LAST) begin
                rcnt <= '0;
                idx  <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end else begin
                rcnt <= rcnt + CW'(1);
            end
            an  <= an_sel;
            seg <= blank_sel ? 7'h7F : seg7(dig_sel);
        end
    end

endmodule

// File: tb/tb_product_display_driver.sv
// Self-checking bench for product_display_driver: directed cases plus random products against a decimal model.
module tb_product_display_driver;

    localparam int DIV = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] m;
    logic       load;
    logic       busy;
    logic       done;
    logic [2:0] an;
    logic [6:0] seg;

    int n_chk = 0;
    int n_fail = 0;
    int k = 0;          // cycles since reset release
    bit scan_on = 1'b0;
    int shown_v = 0;    // value the display is expected to show

    product_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m),
        .load(load),
        .busy(busy),
        .done(done),
        .an  (an),
        .seg (seg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input int kk);
        return ((kk - 1) / DIV) % 3;
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int pos);
        int d;
        bit blank;
        blank = 1'b0;
        d = (pos == 0) ? v % 10 : (pos == 1) ? (v / 10) % 10 : v / 100;
`ifdef LEADING_ZERO_BLANK_EN
        blank = (pos == 2 && v < 100) || (pos == 1 && v < 10);
`endif
        return blank ? 7'h7F : SEG_TAB[d];
    endfunction

    // Advance one clock and check the scan outputs against the model.
    task automatic step();
        logic [2:0] an_exp;
        @(posedge clk);
        #1;
        if (rst) begin
            k = 0;
            check("an_rst", 12'(an), 12'h7);
            check("seg_rst", 12'(seg), 12'h7F);
        end else begin
            k++;
            an_exp = ~(3'b001 << pos_of(k));
            check("an_scan", 12'(an), 12'(an_exp));
            if (scan_on)
                check("seg_digit", 12'(seg), 12'(exp_seg(shown_v, pos_of(k))));
        end
    endtask

    // Load mv, optionally re-pulse load with inj_m during busy cycle inj_at; returns in the done cycle.
    task automatic run_conv(input int mv, input int inj_at, input int inj_m);
        m = 9'(mv);
        load = 1'b1;
        step();
        load = 1'b0;
        check("busy_c1", 12'(busy), 12'h1);
        check("done_c1", 12'(done), 12'h0);
        for (int i = 1; i <= 8; i++) begin
            if (i == inj_at) begin
                m = 9'(inj_m);
                load = 1'b1;
            end
            step();
            load = 1'b0;
            check("busy_mid", 12'(busy), 12'h1);
            check("done_mid", 12'(done), 12'h0);
        end
        step();
        check("busy_end", 12'(busy), 12'h0);
        check("done_end", 12'(done), 12'h1);
    endtask

    task automatic finish_and_scan(input int v);
        shown_v = v;
        scan_on = 1'b1;
        step();
        check("done_fall", 12'(done), 12'h0);
        repeat (12) step();
        scan_on = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        m = '0;
        step();
        step();
        check("busy_rst", 12'(busy), 12'h0);
        check("done_rst", 12'(done), 12'h0);
        rst = 1'b0;

        // Idle scan across several digit-index wraps with zero digits
        shown_v = 0;
        scan_on = 1'b1;
        repeat (24) step();
        scan_on = 1'b0;

        run_conv(225, 0, 0);
        finish_and_scan(225);
        run_conv(511, 0, 0);
        finish_and_scan(511);
        run_conv(0, 0, 0);
        finish_and_scan(0);

        // Load during busy is ignored
        run_conv(100, 4, 37);
        finish_and_scan(100);
        run_conv(37, 0, 0);
        finish_and_scan(37);

        // Load accepted in the done cycle
        run_conv(225, 0, 0);
        run_conv(64, 0, 0);
        finish_and_scan(64);

        // Reset in busy cycle 5 aborts without done and clears the digits
        m = 9'd225;
        load = 1'b1;
        step();
        load = 1'b0;
        repeat (4) step();
        check("busy_c5", 12'(busy), 12'h1);
        rst = 1'b1;
        step();
        check("busy_abort", 12'(busy), 12'h0);
        check("done_abort", 12'(done), 12'h0);
        rst = 1'b0;
        shown_v = 0;
        scan_on = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("no_done_after_abort", 12'(done), 12'h0);
        end
        scan_on = 1'b0;

        // Random products
        for (int i = 0; i < 6; i++) begin
            int v;
            v = int'($urandom_range(511, 0));
            run_conv(v, 0, 0);
            finish_and_scan(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/product_display_driver.md
PRODUCT_DISPLAY_DRIVER -- requirements
Module: product_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clk cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m  input  9  unsigned product from the multiplier stage, range 0..511.
REQ-005 load  input  1  one-cycle strobe that requests conversion of m.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse when new digits are latched.
REQ-008 an  output  3  active-low one-hot digit select: bit0 ones, bit1 tens, bit2 hundreds.
REQ-009 seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.

Function
REQ-010 The converter SHALL be a state machine with two states, IDLE and SHIFT, using sequential double-dabble.
- Uses a 12-bit BCD register plus a 9-bit shift register.
REQ-011 In IDLE with load=1 at edge N, the block SHALL perform these actions.
- Capture m and clear the BCD register.
- Set busy=1 and enter SHIFT.
REQ-012 SHIFT SHALL run exactly 9 iterations, one per clk, at edges N+1..N+9.
- Each iteration first adds 3 to every BCD nibble that is >=5.
- Then it shifts {bcd,shift} left by 1.
REQ-013 At edge N+9 the block SHALL perform these actions.
- Copy the three BCD nibbles into the display digit registers.
- Return to IDLE with busy=0.
- Assert done=1 for exactly the following cycle.
REQ-014 load asserted while busy=1 SHALL be ignored, and the in-flight conversion SHALL be unaffected.
REQ-015 load asserted in the cycle done=1 SHALL start a new conversion, since the state is already IDLE.
REQ-016 The displayed digits SHALL change only at REQ-013 and SHALL hold their value between conversions.
REQ-017 The refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap to 0.
- On each wrap, the digit index SHALL advance 0->1->2->0.
- The refresh counter SHALL run continuously, independent of busy.
REQ-018 The an output SHALL drive exactly one bit low, selected by the digit index.
- The seg output SHALL carry the 7-segment code of the selected digit.
- an and seg SHALL be registered and update together.
REQ-019 Segment codes SHALL be as follows, hex value of {g..a}: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
- Any nibble >9 SHALL drive 7F; this is unreachable in normal operation.

Reset
REQ-020 With rst=1 at a clk edge, the block SHALL set the following values.
- Converter: state IDLE, busy=0, done=0.
- Display: digits 0, refresh counter 0, digit index 0.
- Outputs: an=111, seg=7F.
REQ-021 rst SHALL take priority over load and over any in-progress conversion.
- A conversion aborted by rst SHALL NOT produce done.
- Digits SHALL read 0 after the aborted conversion.
REQ-022 At the first edge after rst deasserts, scanning SHALL begin on digit 0.

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN, when defined, SHALL enable leading-zero blanking.
- The hundreds digit SHALL show 7F when its value is 0.
- The tens digit SHALL show 7F when both hundreds and tens are 0.
- The ones digit SHALL never be blanked.
- an SHALL still scan normally.
REQ-024 When LEADING_ZERO_BLANK_EN is undefined, all three digits SHALL always display their code, including leading zeros.

Verification
REQ-025 REFRESH_DIV=4, m=225, load pulse: results SHALL be as follows.
- busy is high for 9 cycles.
- done pulses at the 10th cycle after load.
- Digits read 2,2,5.
- an=110 gives seg=12; an=101 gives seg=24; an=011 gives seg=24.
REQ-026 m=511 -> digits 5,1,1, with seg 12/79/79; m=0 -> digits 0,0,0, with seg 40 on every digit, or tens/hundreds 7F with LEADING_ZERO_BLANK_EN.
REQ-027 Load m=100, then pulse load with m=37 at busy cycle 4: the response SHALL be as follows.
- A single done pulse occurs.
- Digits read 1,0,0.
- A later load with m=37 gives 0,3,7; with the macro this shows hundreds 7F, tens 30, ones 78.
REQ-028 Reset asserted at busy cycle 5 of conversion m=225: the response SHALL be as follows.
- busy=0 and no done pulse.
- an=111 and seg=7F during reset.
- Digits read 0 afterwards.
REQ-029 REFRESH_DIV=4, idle: an SHALL step 110->101->011->110, changing every 4 cycles.
- Wrap of the digit index SHALL be checked over 24 cycles.
REQ-030 load pulsed in the done cycle with m=64: done SHALL pulse again 10 cycles later, and digits SHALL read 0,6,4.
